// File: rtl/cnn_infer_sequencer.sv
// cnn_infer_sequencer: streams one stored image per start pulse into the CNN datapath and latches the class; optional WAIT timeout via CNN_SEQ_TIMEOUT_EN
module cnn_infer_sequencer #(
  parameter int I_F_BW      = 8,
  parameter int IX          = 28,
  parameter int IY          = 28,
  parameter int IMG_NUM     = 4,
  parameter int CLS_BW      = 2,
  parameter int TIMEOUT_CYC = 100000,
  localparam int PIX_N      = IX * IY,
  localparam int ADDR_BW    = $clog2(IMG_NUM * PIX_N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_start,
  output logic [ADDR_BW-1:0] o_img_addr,
  input  logic [I_F_BW-1:0] i_img_data,
  output logic              o_pix_valid,
  output logic [I_F_BW-1:0] o_pix_data,
  input  logic              i_cnn_valid,
  input  logic [CLS_BW-1:0] i_cnn_class,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err,
  output logic [CLS_BW-1:0] o_class,
  output logic [2:0]        o_led
);
  localparam int PC_BW = $clog2(PIX_N);
  localparam int IW    = IMG_NUM > 1 ? $clog2(IMG_NUM) : 1;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN, WAIT} state_t;
  state_t st, nxt;
  logic [PC_BW-1:0] pix_cnt;
  logic [IW-1:0] img_idx;
  logic drn, iss, iss_q, rom_vld, go, acc, tmo, fin, last_pix;
  assign go       = st == IDLE && i_start;
  assign iss      = go || st == STREAM;
  assign last_pix = pix_cnt == PC_BW'(PIX_N - 1);
  assign acc      = st == WAIT && i_cnn_valid;
  assign fin      = acc || tmo;
  assign o_busy   = st != IDLE;
`ifdef CNN_SEQ_TIMEOUT_EN
  localparam int WC_BW = $clog2(TIMEOUT_CYC + 1);
  logic [WC_BW-1:0] wcnt;
  logic err;
  assign tmo   = st == WAIT && !i_cnn_valid && wcnt == WC_BW'(TIMEOUT_CYC - 1);
  assign o_err = err;
  // WAIT cycle counter restarts on every WAIT entry; error is sticky until next accepted start or result
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wcnt <= '0;
      err  <= 1'b0;
    end else begin
      wcnt <= st == WAIT ? wcnt + 1'b1 : '0;
      err  <= tmo || (err && !acc && !go);
    end
  end
`else
  assign tmo   = 1'b0;
  assign o_err = 1'b0 & (TIMEOUT_CYC > 0);
`endif
  // state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) st <= IDLE;
    else st <= nxt;
  end
  // next-state: start only honoured in IDLE, result only honoured in WAIT
  always_comb begin
    nxt = st;
    if (go) nxt = STREAM;
    if (st == STREAM && last_pix) nxt = DRAIN;
    if (st == DRAIN && drn) nxt = WAIT;
    if (fin) nxt = IDLE;
  end
  // address generation, two-stage valid pipeline matching ROM + output register, result latch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pix_cnt     <= '0;
      img_idx     <= '0;
      drn         <= 1'b0;
      iss_q       <= 1'b0;
      rom_vld     <= 1'b0;
      o_img_addr  <= '0;
      o_pix_valid <= 1'b0;
      o_pix_data  <= '0;
      o_done      <= 1'b0;
      o_class     <= '0;
      o_led       <= '0;
    end else begin
      pix_cnt     <= iss && !last_pix ? pix_cnt + 1'b1 : '0;
      drn         <= st == DRAIN && !drn;
      iss_q       <= iss;
      rom_vld     <= iss_q;
      o_pix_valid <= rom_vld;
      o_pix_data  <= i_img_data;
      o_done      <= acc;
      if (iss) o_img_addr <= ADDR_BW'(img_idx) * ADDR_BW'(PIX_N) + ADDR_BW'(pix_cnt);
      if (acc) o_class <= i_cnn_class;
      if (fin) o_led <= acc && int'(i_cnn_class) < 3 ? 3'b001 << i_cnn_class : 3'b111;
      if (fin) img_idx <= img_idx == IW'(IMG_NUM - 1) ? '0 : img_idx + 1'b1;
    end
  end
endmodule
